univ_shift_seq: RTL and testbench

UNIV_SHIFT_SEQ -- requirements
Module: univ_shift_seq

---
 rtl/univ_shift_seq_pkg.sv | 22 ++
 rtl/univ_shift_seq_mirror_model.sv | 34 +++
 rtl/univ_shift_seq.sv | 157 +++++++++++++++
 tb/tb_univ_shift_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_seq_pkg.sv
// Shared definitions for the universal shift register and its command sequencer.
package univ_shift_seq_pkg;

  // Register width; also the largest step count a single command may use.
  localparam int MAX_STEPS_DEF = 4;

  // Mode encoding, identical on the sequencer command bus and the downstream sel input.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/univ_shift_seq_mirror_model.sv
// Behavioural copy of the downstream universal shift register: it consumes the same
// sel/serial_in/inp the real register sees, so its contents predict the register output.
module univ_shift_seq_mirror_model
  import univ_shift_seq_pkg::*;
#(
  parameter int WIDTH = MAX_STEPS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] mirror
);

  logic [WIDTH-1:0] r_mirror;

  // Hold, shift left, shift right or load, exactly as the downstream register does.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mirror <= '0;
    end else begin
      case (op_e'(sel))
        OP_SHL:  r_mirror <= {r_mirror[WIDTH-2:0], serial_in};
        OP_SHR:  r_mirror <= {serial_in, r_mirror[WIDTH-1:1]};
        OP_LOAD: r_mirror <= inp;
        default: r_mirror <= r_mirror;
      endcase
    end
  end

  assign mirror = r_mirror;

endmodule

// File: rtl/univ_shift_seq.sv
// Command sequencer for a universal shift register: accepts one command at a time,
// expands it into per-cycle sel/serial_in/inp steps, and tracks the register contents.
module univ_shift_seq
  import univ_shift_seq_pkg::*;
#(
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [2:0]           cmd_count,
  input  logic [MAX_STEPS-1:0] cmd_data,
  output logic [1:0]           sel,
  output logic                 serial_in,
  output logic [MAX_STEPS-1:0] inp,
  output logic                 done,
  output logic [MAX_STEPS-1:0] mirror
);

  // Step index width; MAX_STEPS is expected to be a power of two so every index is valid.
  localparam int          STEP_W  = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  // The count field is only 3 bits wide, so the clamp limit lives in that width.
  localparam logic [2:0]  MAX_CNT = 3'(MAX_STEPS);

  state_e               r_state;
  logic [1:0]           r_op;
  logic [MAX_STEPS-1:0] r_data;
  logic [STEP_W-1:0]    r_step;
  logic [STEP_W-1:0]    r_last;
  logic [1:0]           r_sel;
  logic                 r_serial;
  logic [MAX_STEPS-1:0] r_inp;
  logic                 r_done;
  logic                 r_ready;

  state_e               w_state_next;
  logic [1:0]           w_op_next;
  logic [MAX_STEPS-1:0] w_data_next;
  logic [STEP_W-1:0]    w_step_next;
  logic [STEP_W-1:0]    w_last_next;
  logic [1:0]           w_sel_next;
  logic                 w_serial_next;
  logic [MAX_STEPS-1:0] w_inp_next;
  logic                 w_done_next;
  logic                 w_ready_next;
  logic [STEP_W-1:0]    w_last_eff;
  logic [STEP_W-1:0]    w_step_inc;

  assign w_step_inc = r_step + STEP_W'(1);

  // Index of the final step for the offered command: single step for NOP/LOAD,
  // otherwise the count with 0 promoted to 1 and large counts clamped.
  always_comb begin
    w_last_eff = '0;
    if ((cmd_op == OP_SHL) || (cmd_op == OP_SHR)) begin
      if (cmd_count == 3'd0) begin
        w_last_eff = '0;
      end else if (cmd_count > MAX_CNT) begin
        w_last_eff = STEP_W'(MAX_STEPS - 1);
      end else begin
        w_last_eff = STEP_W'(cmd_count - 3'd1);
      end
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    w_state_next  = r_state;
    w_op_next     = r_op;
    w_data_next   = r_data;
    w_step_next   = r_step;
    w_last_next   = r_last;
    w_sel_next    = OP_NOP;
    w_serial_next = 1'b0;
    w_inp_next    = '0;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_ready) begin
          w_state_next  = ST_RUN;
          w_op_next     = cmd_op;
          w_data_next   = cmd_data;
          w_step_next   = '0;
          w_last_next   = w_last_eff;
          w_sel_next    = cmd_op;
          w_serial_next = cmd_data[0];
          w_inp_next    = cmd_data;
        end
      end
      ST_RUN: begin
        if (r_step == r_last) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_step_next   = w_step_inc;
          w_sel_next    = r_op;
          w_serial_next = r_data[w_step_inc];
          w_inp_next    = r_data;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_ready_next = (w_state_next == ST_IDLE);
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_data   <= '0;
      r_step   <= '0;
      r_last   <= '0;
      r_sel    <= OP_NOP;
      r_serial <= 1'b0;
      r_inp    <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_op     <= w_op_next;
      r_data   <= w_data_next;
      r_step   <= w_step_next;
      r_last   <= w_last_next;
      r_sel    <= w_sel_next;
      r_serial <= w_serial_next;
      r_inp    <= w_inp_next;
      r_done   <= w_done_next;
      r_ready  <= w_ready_next;
    end
  end

  assign cmd_ready = r_ready;
  assign sel       = r_sel;
  assign serial_in = r_serial;
  assign inp       = r_inp;
  assign done      = r_done;

  univ_shift_seq_mirror_model #(
    .WIDTH(MAX_STEPS)
  ) u_mirror (
    .clk      (clk),
    .reset    (reset),
    .sel      (r_sel),
    .serial_in(r_serial),
    .inp      (r_inp),
    .mirror   (mirror)
  );

endmodule

// File: tb/tb_univ_shift_seq.sv
// Directed and randomized checks of the shift sequencer against a word-level model.
module tb_univ_shift_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic [1:0] sel;
  logic       serial_in;
  logic [3:0] inp;
  logic       done;
  logic [3:0] mirror;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_mirror;
  logic [3:0] ds_reg;

  always #5 clk = ~clk;

  univ_shift_seq #(.MAX_STEPS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_count(cmd_count),
    .cmd_data (cmd_data),
    .sel      (sel),
    .serial_in(serial_in),
    .inp      (inp),
    .done     (done),
    .mirror   (mirror)
  );

  // Independent downstream register fed from the DUT's drive pins.
  always @(posedge clk) begin
    if (reset) ds_reg <= 4'd0;
    else if (sel == 2'd1) ds_reg <= {ds_reg[2:0], serial_in};
    else if (sel == 2'd2) ds_reg <= {serial_in, ds_reg[3:1]};
    else if (sel == 2'd3) ds_reg <= inp;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_steps(input logic [1:0] op, input logic [2:0] cnt);
    if (op == 2'd0 || op == 2'd3) return 1;
    if (cnt == 3'd0) return 1;
    if (cnt > 3'd4) return 4;
    return int'(cnt);
  endfunction

  // Word-level effect of one step: multiply/divide by two with the serial bit entering.
  function automatic logic [3:0] ref_step(input logic [3:0] m, input logic [1:0] op,
                                          input logic b, input logic [3:0] d);
    int mi;
    int bi;
    mi = int'(m);
    bi = b ? 1 : 0;
    case (op)
      2'd1:    return 4'((mi * 2 + bi) % 16);
      2'd2:    return 4'(mi / 2 + bi * 8);
      2'd3:    return d;
      default: return m;
    endcase
  endfunction

  // One full command: handshake, every step, the done cycle and the return to idle.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input bit keep);
    int n;
    int waitc;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    n = eff_steps(op, cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    @(negedge clk);
    if (keep) begin
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_count = 3'($urandom_range(0, 7));
      cmd_data  = 4'($urandom_range(0, 15));
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      check("step_sel", 32'(sel), 32'(op));
      check("step_serial", 32'(serial_in), 32'(data[k]));
      check("step_inp", 32'(inp), 32'(data));
      check("step_ready", 32'(cmd_ready), 32'd0);
      check("step_done", 32'(done), 32'd0);
      check("step_mirror", 32'(mirror), 32'(exp_mirror));
      exp_mirror = ref_step(exp_mirror, op, data[k], data);
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_sel", 32'(sel), 32'd0);
    check("done_serial", 32'(serial_in), 32'd0);
    check("done_inp", 32'(inp), 32'd0);
    check("done_ready", 32'(cmd_ready), 32'd0);
    check("done_mirror", 32'(mirror), 32'(exp_mirror));
    check("done_vs_reg", 32'(mirror), 32'(ds_reg));
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_mirror", 32'(mirror), 32'(exp_mirror));
    if (!keep) cmd_valid = 1'b0;
    $display("txn op=%0d cnt=%0d data=%b steps=%0d mirror=%b expected=%b",
             op, cnt, data, n, mirror, exp_mirror);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_count  = 3'd0;
    cmd_data   = 4'd0;
    exp_mirror = 4'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_serial", 32'(serial_in), 32'd0);
    check("rst_inp", 32'(inp), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mirror", 32'(mirror), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // LOAD 1010 from reset.
    run_cmd(2'd3, 3'd0, 4'b1010, 1'b0);
    check("load_value", 32'(mirror), 32'hA);

    // SHL by 2 with serial bits 1,1.
    run_cmd(2'd1, 3'd2, 4'b0011, 1'b0);
    check("shl2_value", 32'(mirror), 32'hB);

    // SHR by 1 with serial 0, then count 0 acting as a single step.
    run_cmd(2'd2, 3'd1, 4'b1110, 1'b0);
    check("shr1_value", 32'(mirror), 32'h5);
    run_cmd(2'd2, 3'd0, 4'b0000, 1'b0);
    check("shr0_value", 32'(mirror), 32'h2);

    // Clamp: SHL count 7 from 1111 runs exactly four steps.
    run_cmd(2'd3, 3'd0, 4'b1111, 1'b0);
    run_cmd(2'd1, 3'd7, 4'b0000, 1'b0);
    check("clamp_value", 32'(mirror), 32'h0);

    // NOP leaves the register alone.
    run_cmd(2'd3, 3'd0, 4'b1001, 1'b0);
    run_cmd(2'd0, 3'd5, 4'b0110, 1'b0);
    check("nop_value", 32'(mirror), 32'h9);

    // Reset on step 2 of SHR count 4 aborts with no done pulse.
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_count = 3'd4;
    cmd_data  = 4'b0101;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_step0_sel", 32'(sel), 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("abort_step2_sel", 32'(sel), 32'd2);
    check("abort_step2_serial", 32'(serial_in), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    exp_mirror = 4'd0;
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_mirror", 32'(mirror), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_mirror_hold", 32'(mirror), 32'd0);
    $display("txn reset-abort shr cnt=4 mirror=%b", mirror);

    // Back-to-back random traffic with cmd_valid held high throughout.
    for (int i = 0; i < 24; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), (i != 23));
    end
    check("final_vs_reg", 32'(mirror), 32'(ds_reg));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
